// File: rtl/diagv2_pipe_regs_pkg.sv
// Shared widths and control-bus field offsets for the diag-v2 front/middle pipeline registers.
// Control buses are packed MSB-first exactly as the decoder emits them; regWrite is always bit 0.
package diagv2_pipe_regs_pkg;

  localparam int XLEN   = 64;
  localparam int ILEN   = 32;
  localparam int ALUC_W = 4;
  localparam int MEMT_W = 3;
  localparam int RSLT_W = 3;
  localparam int REG_W  = 5;

  localparam int CE_W = 12 + ALUC_W + MEMT_W + RSLT_W;
  localparam int CM_W = 2 + MEMT_W + RSLT_W;

  // ID/EX control field positions, built up from regWrite at bit 0
  localparam int CE_REGWRITE       = 0;
  localparam int CE_RESULTSRC_LSB  = CE_REGWRITE + 1;
  localparam int CE_MEMTYPE_LSB    = CE_RESULTSRC_LSB + RSLT_W;
  localparam int CE_MEMWRITE       = CE_MEMTYPE_LSB + MEMT_W;
  localparam int CE_BRANCH         = CE_MEMWRITE + 1;
  localparam int CE_JALR           = CE_BRANCH + 1;
  localparam int CE_JAL            = CE_JALR + 1;
  localparam int CE_ALU32          = CE_JAL + 1;
  localparam int CE_ALUCONTROL_LSB = CE_ALU32 + 1;
  localparam int CE_ALUSRC         = CE_ALUCONTROL_LSB + ALUC_W;
  localparam int CE_FUNCT3_LSB     = CE_ALUSRC + 1;

  localparam int CM_REGWRITE      = 0;
  localparam int CM_RESULTSRC_LSB = CM_REGWRITE + 1;
  localparam int CM_MEMTYPE_LSB   = CM_RESULTSRC_LSB + RSLT_W;
  localparam int CM_MEMWRITE      = CM_MEMTYPE_LSB + MEMT_W;

  localparam int IFID_W  = ILEN + 2 * XLEN;
  localparam int IDEX_W  = CE_W + 5 * XLEN + 3 * REG_W;
  localparam int EXMEM_W = CM_W + 5 * XLEN + REG_W;

  typedef struct packed {
    logic              memWrite;
    logic [MEMT_W-1:0] memType;
    logic [RSLT_W-1:0] resultSrc;
    logic              regWrite;
  } memCtrl_t;

  // Narrows an ID/EX control word to the EX/MEM control word the execute stage forwards.
  function automatic logic [CM_W-1:0] toMemCtrl(input logic [CE_W-1:0] ctrlE);
    memCtrl_t m;
    m.memWrite  = ctrlE[CE_MEMWRITE];
    m.memType   = ctrlE[CE_MEMTYPE_LSB +: MEMT_W];
    m.resultSrc = ctrlE[CE_RESULTSRC_LSB +: RSLT_W];
    m.regWrite  = ctrlE[CE_REGWRITE];
    return m;
  endfunction

  function automatic logic isBubble(input logic [CM_W-1:0] ctrlM);
    return !ctrlM[CM_REGWRITE] && !ctrlM[CM_MEMWRITE];
  endfunction

endpackage

// File: rtl/diagv2_pipe_regs_if.sv
// Stage-boundary bus between the diag-v2 core datapath (master) and its pipeline register bank (slave).
interface diagv2_pipe_regs_if;
  import diagv2_pipe_regs_pkg::*;

  logic stallD;
  logic flushD;
  logic flushE;

  logic [ILEN-1:0]  instrF;
  logic [XLEN-1:0]  PCF;
  logic [XLEN-1:0]  PCPlus4F;
  logic [ILEN-1:0]  instrD;
  logic [XLEN-1:0]  PCD;
  logic [XLEN-1:0]  PCPlus4D;

  logic [CE_W-1:0]  ctrlD;
  logic [XLEN-1:0]  readData1D;
  logic [XLEN-1:0]  readData2D;
  logic [XLEN-1:0]  PCD_x;
  logic [REG_W-1:0] rs1D;
  logic [REG_W-1:0] rs2D;
  logic [REG_W-1:0] rdD;
  logic [XLEN-1:0]  immExtD;
  logic [XLEN-1:0]  PCPlus4D_x;
  logic [CE_W-1:0]  ctrlE;
  logic [XLEN-1:0]  readData1E;
  logic [XLEN-1:0]  readData2E;
  logic [XLEN-1:0]  PCE;
  logic [REG_W-1:0] rs1E;
  logic [REG_W-1:0] rs2E;
  logic [REG_W-1:0] rdE;
  logic [XLEN-1:0]  immExtE;
  logic [XLEN-1:0]  PCPlus4E;

  logic [CM_W-1:0]  ctrlE_x;
  logic [XLEN-1:0]  ALUResultE;
  logic [XLEN-1:0]  writeDataE;
  logic [XLEN-1:0]  PCTargetE;
  logic [REG_W-1:0] rdE_x;
  logic [XLEN-1:0]  immExtE_x;
  logic [XLEN-1:0]  PCPlus4E_x;
  logic [CM_W-1:0]  ctrlM;
  logic [XLEN-1:0]  ALUResultM;
  logic [XLEN-1:0]  writeDataM;
  logic [XLEN-1:0]  PCTargetM;
  logic [REG_W-1:0] rdM;
  logic [XLEN-1:0]  immExtM;
  logic [XLEN-1:0]  PCPlus4M;

  modport master (
    output stallD, flushD, flushE,
    output instrF, PCF, PCPlus4F,
    output ctrlD, readData1D, readData2D, PCD_x, rs1D, rs2D, rdD, immExtD, PCPlus4D_x,
    output ctrlE_x, ALUResultE, writeDataE, PCTargetE, rdE_x, immExtE_x, PCPlus4E_x,
    input  instrD, PCD, PCPlus4D,
    input  ctrlE, readData1E, readData2E, PCE, rs1E, rs2E, rdE, immExtE, PCPlus4E,
    input  ctrlM, ALUResultM, writeDataM, PCTargetM, rdM, immExtM, PCPlus4M
  );

  modport slave (
    input  stallD, flushD, flushE,
    input  instrF, PCF, PCPlus4F,
    input  ctrlD, readData1D, readData2D, PCD_x, rs1D, rs2D, rdD, immExtD, PCPlus4D_x,
    input  ctrlE_x, ALUResultE, writeDataE, PCTargetE, rdE_x, immExtE_x, PCPlus4E_x,
    output instrD, PCD, PCPlus4D,
    output ctrlE, readData1E, readData2E, PCE, rs1E, rs2E, rdE, immExtE, PCPlus4E,
    output ctrlM, ALUResultM, writeDataM, PCTargetM, rdM, immExtM, PCPlus4M
  );

endinterface

// File: rtl/diagv2_pipe_regs_pipe_reg.sv
// Generic pipeline flop: async active-low reset, then synchronous clear, then load enable.
// Clear outranks enable so a flush always wins over a stall on the same edge.
module pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/diagv2_pipe_regs.sv
// IF/ID, ID/EX and EX/MEM stage registers of the diag-v2 RV64 core; all-zero contents are a bubble.
module diagv2_pipe_regs
  import diagv2_pipe_regs_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  diagv2_pipe_regs_if.slave  bus
);

  logic [IFID_W-1:0]  ifIdD;
  logic [IFID_W-1:0]  ifIdQ;
  logic [IDEX_W-1:0]  idExD;
  logic [IDEX_W-1:0]  idExQ;
  logic [EXMEM_W-1:0] exMemD;
  logic [EXMEM_W-1:0] exMemQ;

  assign ifIdD = {bus.instrF, bus.PCF, bus.PCPlus4F};
  assign {bus.instrD, bus.PCD, bus.PCPlus4D} = ifIdQ;

  pipe_reg #(.WIDTH(IFID_W)) ifIdReg (
    .clk    (clk),
    .reset  (reset),
    .clear  (bus.flushD),
    .enable (!bus.stallD),
    .d      (ifIdD),
    .q      (ifIdQ)
  );

  assign idExD = {bus.ctrlD, bus.readData1D, bus.readData2D, bus.PCD_x,
                  bus.rs1D, bus.rs2D, bus.rdD, bus.immExtD, bus.PCPlus4D_x};
  assign {bus.ctrlE, bus.readData1E, bus.readData2E, bus.PCE,
          bus.rs1E, bus.rs2E, bus.rdE, bus.immExtE, bus.PCPlus4E} = idExQ;

  // A flushed ID/EX clears data and register indices too, so no stale rd can match in forwarding.
  pipe_reg #(.WIDTH(IDEX_W)) idExReg (
    .clk    (clk),
    .reset  (reset),
    .clear  (bus.flushE),
    .enable (1'b1),
    .d      (idExD),
    .q      (idExQ)
  );

  assign exMemD = {bus.ctrlE_x, bus.ALUResultE, bus.writeDataE, bus.PCTargetE,
                   bus.rdE_x, bus.immExtE_x, bus.PCPlus4E_x};
  assign {bus.ctrlM, bus.ALUResultM, bus.writeDataM, bus.PCTargetM,
          bus.rdM, bus.immExtM, bus.PCPlus4M} = exMemQ;

  pipe_reg #(.WIDTH(EXMEM_W)) exMemReg (
    .clk    (clk),
    .reset  (reset),
    .clear  (1'b0),
    .enable (1'b1),
    .d      (exMemD),
    .q      (exMemQ)
  );

endmodule

// File: tb/tb_diagv2_pipe_regs.sv
// Scoreboard bench for diagv2_pipe_regs: directed stage scenarios followed by randomised hazard traffic.
module tb_diagv2_pipe_regs;
  import diagv2_pipe_regs_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   assertCount = 0;
  int   failCount = 0;

  always #5 clk = ~clk;

  diagv2_pipe_regs_if busIf ();

  diagv2_pipe_regs dut (
    .clk   (clk),
    .reset (reset),
    .bus   (busIf.slave)
  );

  typedef struct packed {
    logic [IFID_W-1:0]  ifId;
    logic [IDEX_W-1:0]  idEx;
    logic [EXMEM_W-1:0] exMem;
  } expect_t;

  expect_t            scoreQ[$];
  logic [IFID_W-1:0]  mIfId = '0;
  logic [IDEX_W-1:0]  mIdEx = '0;
  logic [EXMEM_W-1:0] mExMem = '0;

  function automatic logic [IFID_W-1:0] ifInVec();
    return {busIf.instrF, busIf.PCF, busIf.PCPlus4F};
  endfunction

  function automatic logic [IFID_W-1:0] ifOutVec();
    return {busIf.instrD, busIf.PCD, busIf.PCPlus4D};
  endfunction

  function automatic logic [IDEX_W-1:0] idInVec();
    return {busIf.ctrlD, busIf.readData1D, busIf.readData2D, busIf.PCD_x,
            busIf.rs1D, busIf.rs2D, busIf.rdD, busIf.immExtD, busIf.PCPlus4D_x};
  endfunction

  function automatic logic [IDEX_W-1:0] idOutVec();
    return {busIf.ctrlE, busIf.readData1E, busIf.readData2E, busIf.PCE,
            busIf.rs1E, busIf.rs2E, busIf.rdE, busIf.immExtE, busIf.PCPlus4E};
  endfunction

  function automatic logic [EXMEM_W-1:0] exInVec();
    return {busIf.ctrlE_x, busIf.ALUResultE, busIf.writeDataE, busIf.PCTargetE,
            busIf.rdE_x, busIf.immExtE_x, busIf.PCPlus4E_x};
  endfunction

  function automatic logic [EXMEM_W-1:0] exOutVec();
    return {busIf.ctrlM, busIf.ALUResultM, busIf.writeDataM, busIf.PCTargetM,
            busIf.rdM, busIf.immExtM, busIf.PCPlus4M};
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [383:0] observed, input logic [383:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    busIf.stallD = 1'b0; busIf.flushD = 1'b0; busIf.flushE = 1'b0;
    busIf.instrF = '0; busIf.PCF = '0; busIf.PCPlus4F = '0;
    busIf.ctrlD = '0; busIf.readData1D = '0; busIf.readData2D = '0; busIf.PCD_x = '0;
    busIf.rs1D = '0; busIf.rs2D = '0; busIf.rdD = '0; busIf.immExtD = '0; busIf.PCPlus4D_x = '0;
    busIf.ctrlE_x = '0; busIf.ALUResultE = '0; busIf.writeDataE = '0; busIf.PCTargetE = '0;
    busIf.rdE_x = '0; busIf.immExtE_x = '0; busIf.PCPlus4E_x = '0;
  endtask

  task automatic applyStimulus(input bit withHazards);
    busIf.stallD = withHazards && ($urandom_range(3) == 0);
    busIf.flushD = withHazards && ($urandom_range(6) == 0);
    busIf.flushE = withHazards && ($urandom_range(6) == 0);
    busIf.instrF = $urandom; busIf.PCF = rand64(); busIf.PCPlus4F = rand64();
    busIf.ctrlD = CE_W'($urandom); busIf.readData1D = rand64(); busIf.readData2D = rand64();
    busIf.PCD_x = rand64(); busIf.rs1D = REG_W'($urandom); busIf.rs2D = REG_W'($urandom);
    busIf.rdD = REG_W'($urandom); busIf.immExtD = rand64(); busIf.PCPlus4D_x = rand64();
    busIf.ctrlE_x = CM_W'($urandom); busIf.ALUResultE = rand64(); busIf.writeDataE = rand64();
    busIf.PCTargetE = rand64(); busIf.rdE_x = REG_W'($urandom); busIf.immExtE_x = rand64();
    busIf.PCPlus4E_x = rand64();
  endtask

  // Predict the next state from the current inputs, queue it, then compare after the edge.
  task automatic stepCycle();
    expect_t e;
    if (busIf.flushD)      e.ifId = '0;
    else if (busIf.stallD) e.ifId = mIfId;
    else                   e.ifId = ifInVec();
    e.idEx  = busIf.flushE ? '0 : idInVec();
    e.exMem = exInVec();
    mIfId = e.ifId; mIdEx = e.idEx; mExMem = e.exMem;
    scoreQ.push_back(e);
    @(posedge clk);
    #1;
    e = scoreQ.pop_front();
    checkOutput("ifId", 384'(ifOutVec()), 384'(e.ifId));
    checkOutput("idEx", 384'(idOutVec()), 384'(e.idEx));
    checkOutput("exMem", 384'(exOutVec()), 384'(e.exMem));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ifId"}, 384'(ifOutVec()), '0);
    checkOutput({tag, "_idEx"}, 384'(idOutVec()), '0);
    checkOutput({tag, "_exMem"}, 384'(exOutVec()), '0);
    mIfId = '0; mIdEx = '0; mExMem = '0;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0);
    busIf.instrF = 32'h00500093;
    #1 reset = 1'b0;
    #1 checkAllZero("resetAsync");
    @(negedge clk);
    @(negedge clk);
    checkAllZero("resetHeld");
    reset = 1'b1;
    stepCycle();
    checkOutput("releaseInstrD", 384'(busIf.instrD), 384'(32'h00500093));

    clearInputs();
    busIf.instrF = 32'h00A00113; busIf.PCF = 64'h100; busIf.PCPlus4F = 64'h104;
    stepCycle();
    checkOutput("flowPCD", 384'(busIf.PCD), 384'(64'h100));
    busIf.PCD_x = busIf.PCD; busIf.ALUResultE = 64'hDEAD;
    stepCycle();
    checkOutput("flowPCE", 384'(busIf.PCE), 384'(64'h100));
    checkOutput("flowALUResultM", 384'(busIf.ALUResultM), 384'(64'hDEAD));

    busIf.stallD = 1'b1; busIf.instrF = 32'h00000013; busIf.PCF = 64'h200; busIf.PCPlus4F = 64'h204;
    busIf.readData1D = 64'h1234; busIf.ALUResultE = 64'hBEEF;
    stepCycle();
    checkOutput("stallInstrD", 384'(busIf.instrD), 384'(32'h00A00113));
    checkOutput("stallPCD", 384'(busIf.PCD), 384'(64'h100));
    checkOutput("stallPCPlus4D", 384'(busIf.PCPlus4D), 384'(64'h104));
    checkOutput("stallReadData1E", 384'(busIf.readData1E), 384'(64'h1234));
    checkOutput("stallALUResultM", 384'(busIf.ALUResultM), 384'(64'hBEEF));

    busIf.flushD = 1'b1;
    stepCycle();
    checkOutput("flushStallInstrD", 384'(busIf.instrD), '0);
    checkOutput("flushStallPCD", 384'(busIf.PCD), '0);

    busIf.flushD = 1'b0; busIf.stallD = 1'b0; busIf.flushE = 1'b1;
    busIf.ctrlD = 22'h2A5A1; busIf.rdD = 5'd3; busIf.ALUResultE = 64'hCAFE;
    stepCycle();
    checkOutput("flushECtrlE", 384'(busIf.ctrlE), '0);
    checkOutput("flushERdE", 384'(busIf.rdE), '0);
    checkOutput("flushEALUResultM", 384'(busIf.ALUResultM), 384'(64'hCAFE));

    busIf.flushE = 1'b0; busIf.ctrlE_x = 8'hFF;
    stepCycle();
    checkOutput("ctrlM", 384'(busIf.ctrlM), 384'(8'hFF));
    checkOutput("ctrlMRegWrite", 384'(busIf.ctrlM[0]), 384'(1'b1));
    checkOutput("ctrlMMemWrite", 384'(busIf.ctrlM[7]), 384'(1'b1));
    checkOutput("ctrlMMemType", 384'(busIf.ctrlM[6:4]), 384'(3'b111));

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1);
      if (i == 150) begin
        reset = 1'b0;
        #1 checkAllZero("resetMid");
        @(negedge clk);
        reset = 1'b1;
      end
      stepCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
